prewish_mask_arbiter: RTL
=========================

# prewish_mask_arbiter

Shares the blinky mask-load strobe interface between several requesters, e.g. the test-driven mentor and a button-driven pattern selector. Each requester holds a level request with an 8-bit mask; the arbiter grants one at a time, acknowledges it, and forwards a single-cycle STB_O/DAT_O write to the blinky. After each write it enforces a programmable hold-off so the blinky always sees well-separated strobes.

## Interface
- NREQ, 2: number of requesters, 2..8.
- DW, 8: mask data width.
- HOLDOFF, 3: idle cycles enforced after each STB_O pulse, 0..255.
- CLK_I  in  1  single clock; all logic on posedge.
- RST_I  in  1  reset, synchronous, active-low.
- REQ_STB_I  in  NREQ  per-requester request level; bit i belongs to requester i.
- REQ_DAT_I  in  NREQ*DW  requester i's mask at bits [i*DW +: DW].
- REQ_ACK_O  out  NREQ  one-cycle grant acknowledge, one-hot or zero.
- STB_O  out  1  one-cycle write strobe to the blinky.
- DAT_O  out  DW  mask to the blinky; valid while STB_O=1; holds the last value otherwise.
- BUSY_O  out  1  high in XFER and HOLD.
- o_alive  out  1  debug LED; toggles on every grant.

## Operation
- States: IDLE=00, XFER=01, HOLD=11. Code 10 is illegal. In state 10: all outputs low, next state IDLE.
- IDLE: if any REQ_STB_I bit is set, the picker selects winner w. On that edge: DAT_O <= REQ_DAT_I[w], REQ_ACK_O[w] <= 1, STB_O <= 1, alive toggles, state <= XFER. If no bit is set, stay in IDLE with all strobes low.
- XFER, exactly one cycle: STB_O=1 and REQ_ACK_O[w]=1 are visible.
  - On exit: strobes clear and the round-robin pointer <= (w+1) mod NREQ.
  - If HOLDOFF=0, state <= IDLE. Otherwise the counter <= HOLDOFF-1 and state <= HOLD.
- HOLD: REQ_STB_I is ignored. The counter decrements each cycle, and at 0 the state <= IDLE.
- Requester rule: hold REQ_STB_I and REQ_DAT_I stable until REQ_ACK_O[i] is seen, then deassert on the following edge. A request still high in IDLE afterwards is a new request.
- Picker (round-robin): the first set bit scanning from the pointer upward, wrapping at NREQ.
- Reset (RST_I=0 at any edge, including mid-XFER or mid-HOLD):
  - state IDLE, pointer 0, counter 0;
  - STB_O, REQ_ACK_O, BUSY_O, DAT_O and o_alive all 0.
  - An interrupted grant is lost without retry; the requester still holding its request is re-arbitrated after reset releases.

## Timing
- Request sampled high in IDLE at cycle n: REQ_ACK_O and STB_O are high in cycle n+1 only, and DAT_O is valid in n+1.
- Back in IDLE at cycle n+2+HOLDOFF. The earliest next STB_O is n+3+HOLDOFF, so the minimum strobe spacing is HOLDOFF+2 cycles.
- Simultaneous requests in IDLE: exactly one is granted per XFER and the others wait. No request starves; worst-case wait is (NREQ-1)*(HOLDOFF+2) cycles after the current transfer ends.
- Pointer wrap: after granting NREQ-1, the pointer becomes 0.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- PREWISH_ARB_FIXED_PRIO_EN defined: the lowest set index always wins. The pointer register is removed and not updated.
- Undefined (default): round-robin as described above.

## Structure
- Package prewish_pkg holds the state encodings ST_IDLE, ST_XFER and ST_HOLD, and the default DW=8 shared with the blinky and mentor.
- Sub-module prewish_rr_pick: a combinational rotate-and-priority-encode.
  - Inputs: request vector and pointer.
  - Outputs: valid flag and winner index.
  - Under PREWISH_ARB_FIXED_PRIO_EN, the pointer input is tied to 0.
- The top level holds the FSM, the data/ack/strobe registers, the hold-off counter and the alive toggle.

## Test plan
- **Reset values:** hold RST_I=0 for 3 cycles with REQ_STB_I=2'b11, then release. Required: all outputs 0 during reset, and the first grant goes to requester 0.
- **Single request:** requester 1 with mask 8'hB4, request raised in cycle n. Required: REQ_ACK_O=2'b10, STB_O=1 and DAT_O=8'hB4 in n+1 only, BUSY_O low again at n+5 (HOLDOFF=3).
- **Contention:** both requesters held high continuously, masks 8'h0F and 8'hF0. Required: strobes alternate 0F, F0, 0F, spaced 5 cycles apart. With PREWISH_ARB_FIXED_PRIO_EN: 0F every time.
- **Request during hold-off:** requester 0 rises 1 cycle after requester 1's strobe. Required: no ACK before IDLE; ACK arrives exactly HOLDOFF+2 cycles after the prior strobe.
- **Reset mid-operation:** RST_I=0 during HOLD with requester 0 pending. Required: no strobe during reset; requester 0 granted 1 cycle after release, DAT_O correct.
- **HOLDOFF=0 build with continuous requests:** strobes every 2 cycles; o_alive toggles on each grant.

Source files
------------

// File: rtl/prewish_pkg.sv
// prewish_pkg: shared types and constants for the prewish blinky/mentor/arbiter
// family. Optional build macro honoured by the arbiter: PREWISH_ARB_FIXED_PRIO_EN.
package prewish_pkg;

  // Arbiter FSM encodings; 2'b10 is deliberately left unused (illegal).
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_XFER = 2'b01,
    ST_HOLD = 2'b11
  } state_t;

  // Mask width shared with the blinky and the mentor.
  localparam int DW_DEF = 8;

  // Hold-off counter width; HOLDOFF is limited to 0..255.
  localparam int CW = 8;

endpackage

// File: rtl/prewish_mask_arbiter_if.sv
// prewish_mask_arbiter_if: requester-side request/ack bus plus the strobed mask
// write towards the blinky. Build macro of the arbiter: PREWISH_ARB_FIXED_PRIO_EN.
interface prewish_mask_arbiter_if
  import prewish_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int DW   = DW_DEF
);

  logic [NREQ-1:0]    REQ_STB_I;
  logic [NREQ*DW-1:0] REQ_DAT_I;
  logic [NREQ-1:0]    REQ_ACK_O;
  logic               STB_O;
  logic [DW-1:0]      DAT_O;
  logic               BUSY_O;

  // Requester / blinky side of the bus.
  modport master (
    output REQ_STB_I, REQ_DAT_I,
    input  REQ_ACK_O, STB_O, DAT_O, BUSY_O
  );

  // Arbiter side of the bus.
  modport slave (
    input  REQ_STB_I, REQ_DAT_I,
    output REQ_ACK_O, STB_O, DAT_O, BUSY_O
  );

endinterface

// File: rtl/prewish_rr_pick.sv
// prewish_rr_pick: combinational rotate-and-priority-encode. Returns the first
// set request scanning upward from ptr_i, wrapping at NREQ. With the build macro
// PREWISH_ARB_FIXED_PRIO_EN the parent ties ptr_i to zero (fixed priority).
module prewish_rr_pick #(
  parameter int NREQ = 2,
  parameter int PW   = 1
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [PW-1:0]   ptr_i,
  output logic            valid_o,
  output logic [PW-1:0]   win_o
);

  logic [PW:0] sum_s;

  // Scan offsets from highest to lowest so the smallest offset from the pointer is the last hit written.
  always_comb begin
    valid_o = 1'b0;
    win_o   = {PW{1'b0}};
    sum_s   = {(PW+1){1'b0}};
    for (int k = NREQ - 1; k >= 0; k--) begin
      sum_s = {1'b0, ptr_i} + (PW+1)'(k);
      if (sum_s >= (PW+1)'(NREQ)) begin
        sum_s = sum_s - (PW+1)'(NREQ);
      end else begin
        sum_s = sum_s;
      end
      if (req_i[sum_s[PW-1:0]]) begin
        valid_o = 1'b1;
        win_o   = sum_s[PW-1:0];
      end else begin
        win_o   = win_o;
      end
    end
  end

endmodule

// File: rtl/prewish_mask_arbiter.sv
// prewish_mask_arbiter: grants one requester at a time, forwards its mask to the
// blinky as a one-cycle STB_O/DAT_O write and then idles HOLDOFF cycles.
// Build macro: PREWISH_ARB_FIXED_PRIO_EN selects fixed lowest-index priority
// (no pointer register); undefined gives round-robin.
module prewish_mask_arbiter
  import prewish_pkg::*;
#(
  parameter int NREQ    = 2,
  parameter int DW      = DW_DEF,
  parameter int HOLDOFF = 3
) (
  input  logic                   CLK_I,
  input  logic                   RST_I,
  prewish_mask_arbiter_if.slave  bus,
  output logic                   o_alive
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              pick_valid_s;
  logic [PW-1:0]     pick_win_s;
  logic [PW-1:0]     pick_ptr_s;
  logic              legal_s;

  logic [NREQ-1:0]   ack_q, ack_d;
  logic              stb_q, stb_d;
  logic              busy_q, busy_d;
  logic [DW-1:0]     dat_q, dat_d;
  logic              alive_q, alive_d;

`ifdef PREWISH_ARB_FIXED_PRIO_EN
  assign pick_ptr_s = {PW{1'b0}};
`else
  logic [PW-1:0]     ptr_q, ptr_d;
  logic [PW-1:0]     win_q, win_d;

  assign pick_ptr_s = ptr_q;

  // Remember the winner at grant time and step the pointer past it when the transfer completes.
  always_comb begin
    win_d = win_q;
    ptr_d = ptr_q;
    if ((state_q == ST_IDLE) && pick_valid_s) begin
      win_d = pick_win_s;
    end else if (state_q == ST_XFER) begin
      ptr_d = (win_q == PW'(NREQ - 1)) ? {PW{1'b0}} : win_q + PW'(1);
    end else begin
      win_d = win_q;
    end
  end

  // Round-robin pointer and captured winner.
  always_ff @(posedge CLK_I) begin
    if (!RST_I) begin
      ptr_q <= {PW{1'b0}};
      win_q <= {PW{1'b0}};
    end else begin
      ptr_q <= ptr_d;
      win_q <= win_d;
    end
  end
`endif

  prewish_rr_pick #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_pick (
    .req_i   (bus.REQ_STB_I),
    .ptr_i   (pick_ptr_s),
    .valid_o (pick_valid_s),
    .win_o   (pick_win_s)
  );

  // FSM state and hold-off counter register.
  always_ff @(posedge CLK_I) begin
    if (!RST_I) begin
      state_q <= ST_IDLE;
      cnt_q   <= {CW{1'b0}};
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic: IDLE grants, XFER lasts one cycle, HOLD counts down the hold-off.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_valid_s) begin
          state_d = ST_XFER;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_XFER: begin
        if (HOLDOFF == 0) begin
          state_d = ST_IDLE;
          cnt_d   = {CW{1'b0}};
        end else begin
          state_d = ST_HOLD;
          cnt_d   = CW'(HOLDOFF - 1);
        end
      end
      ST_HOLD: begin
        if (cnt_q == {CW{1'b0}}) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d   = cnt_q - CW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = {CW{1'b0}};
      end
    endcase
  end

  // Output next values: a grant loads mask/ack/strobe and flips the alive LED; strobes last one cycle.
  always_comb begin
    ack_d   = {NREQ{1'b0}};
    stb_d   = 1'b0;
    dat_d   = dat_q;
    alive_d = alive_q;
    busy_d  = (state_d == ST_XFER) || (state_d == ST_HOLD);
    if ((state_q == ST_IDLE) && pick_valid_s) begin
      stb_d   = 1'b1;
      alive_d = ~alive_q;
      for (int i = 0; i < NREQ; i++) begin
        if (pick_win_s == PW'(i)) begin
          ack_d[i] = 1'b1;
          dat_d    = bus.REQ_DAT_I[i*DW +: DW];
        end else begin
          ack_d[i] = 1'b0;
        end
      end
    end else begin
      stb_d = 1'b0;
    end
  end

  // Registered outputs.
  always_ff @(posedge CLK_I) begin
    if (!RST_I) begin
      ack_q   <= {NREQ{1'b0}};
      stb_q   <= 1'b0;
      busy_q  <= 1'b0;
      dat_q   <= {DW{1'b0}};
      alive_q <= 1'b0;
    end else begin
      ack_q   <= ack_d;
      stb_q   <= stb_d;
      busy_q  <= busy_d;
      dat_q   <= dat_d;
      alive_q <= alive_d;
    end
  end

  // An upset into the unused state code forces every output low until IDLE is re-entered.
  assign legal_s = (state_q == ST_IDLE) || (state_q == ST_XFER) || (state_q == ST_HOLD);

  assign bus.REQ_ACK_O = legal_s ? ack_q : {NREQ{1'b0}};
  assign bus.STB_O     = legal_s & stb_q;
  assign bus.BUSY_O    = legal_s & busy_q;
  assign bus.DAT_O     = legal_s ? dat_q : {DW{1'b0}};
  assign o_alive       = legal_s & alive_q;

endmodule
